// File: rtl/w_stream_gen_if.sv
// ---------------------------------------------------------------------------
// w_stream_gen_if
// Bundle of the control inputs and serial outputs of w_stream_gen.
//   Pattern [WIDTH]  bits to replay, bit 0 first
//   Len     [LEN_W]  number of bits to send (clamped to WIDTH)
//   Start            level input, rising edge launches a transfer
//   Stop             synchronous abort
//   Repeat           loop the captured pattern instead of finishing
//   w                serial bit to the detector
//   Step             high on the first cycle of every presented bit
//   Busy             transfer in progress
//   Done             one-cycle pulse on normal completion
//   BitIdx  [LEN_W]  index of the bit currently on w
// master: the generator side; slave: the side driving controls / watching w.
// ---------------------------------------------------------------------------
interface w_stream_gen_if #(
  parameter int WIDTH = 8
);
  localparam int LEN_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] Pattern;
  logic [LEN_W-1:0] Len;
  logic             Start;
  logic             Stop;
  logic             Repeat;
  logic             w;
  logic             Step;
  logic             Busy;
  logic             Done;
  logic [LEN_W-1:0] BitIdx;

  modport master (
    input  Pattern, Len, Start, Stop, Repeat,
    output w, Step, Busy, Done, BitIdx
  );

  modport slave (
    output Pattern, Len, Start, Stop, Repeat,
    input  w, Step, Busy, Done, BitIdx
  );
endinterface

// File: rtl/w_stream_gen.sv
// ---------------------------------------------------------------------------
// w_stream_gen
// Captures a pattern and replays it LSB-first on w, one bit every DIV clocks,
// with a one-cycle Step strobe at the start of every bit.
// Ports:
//   Clock   sole clock, posedge
//   Resetn  asynchronous active-low reset
//   sif     w_stream_gen_if.master (Pattern/Len/Start/Stop/Repeat in,
//           w/Step/Busy/Done/BitIdx out, all outputs registered)
// Optional feature: define WSTREAM_PARITY_EN to append one bit equal to the
// XOR of the captured data bits (BitIdx = L) after the data bits.
// ---------------------------------------------------------------------------
module w_stream_gen #(
  parameter int WIDTH = 8,
  parameter int DIV   = 4
) (
  input  logic           Clock,
  input  logic           Resetn,
  w_stream_gen_if.master sif
);
  localparam int LEN_W = $clog2(WIDTH + 1);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [LEN_W-1:0] WIDTH_L  = LEN_W'(WIDTH);
  localparam logic [LEN_W-1:0] IDX_ZERO = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0] IDX_ONE  = LEN_W'(1);
  localparam logic [DIV_W-1:0] DIV_ZERO = {DIV_W{1'b0}};
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  logic [1:0]       state_r;
  logic             start_prev_r;
  logic [WIDTH-1:0] pat_r;
  logic [LEN_W-1:0] len_r;
  logic [DIV_W-1:0] div_r;
  logic [LEN_W-1:0] bit_idx_r;
  logic             w_r;
  logic             step_r;
  logic             busy_r;
  logic             done_r;

  logic [LEN_W-1:0] len_eff_s;
  logic [LEN_W-1:0] last_idx_s;
  logic [LEN_W-1:0] nxt_idx_s;
  logic [WIDTH-1:0] pat_shift_s;
  logic             nxt_bit_s;
  logic             launch_s;
  logic             bit_end_s;
  logic             last_bit_s;

`ifdef WSTREAM_PARITY_EN
  logic             par_r;

  // XOR of the first len bits of pat
  function automatic logic parity_of(input logic [WIDTH-1:0] pat,
                                     input logic [LEN_W-1:0] len);
    logic p;
    p = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i < int'(len)) begin
        p = p ^ pat[i];
      end
    end
    return p;
  endfunction
`endif

  // Clamp requested length to the pattern width
  always_comb begin
    if (sif.Len > WIDTH_L) begin
      len_eff_s = WIDTH_L;
    end else begin
      len_eff_s = sif.Len;
    end
  end

  assign launch_s  = (state_r == ST_IDLE) && sif.Start && !start_prev_r &&
                     !sif.Stop && (len_eff_s != IDX_ZERO);
  assign bit_end_s = (div_r == DIV_LAST);

`ifdef WSTREAM_PARITY_EN
  // The parity bit sits at index len_r, after the data bits
  assign last_idx_s = len_r;
`else
  assign last_idx_s = len_r - IDX_ONE;
`endif

  assign last_bit_s  = (bit_idx_r == last_idx_s);
  assign nxt_idx_s   = last_bit_s ? IDX_ZERO : (bit_idx_r + IDX_ONE);
  // Shift instead of a variable bit-select so the index may exceed WIDTH-1
  assign pat_shift_s = pat_r >> nxt_idx_s;

  // Select the bit to present next from the captured copy
  always_comb begin
    nxt_bit_s = pat_shift_s[0];
`ifdef WSTREAM_PARITY_EN
    if (nxt_idx_s == len_r) begin
      nxt_bit_s = par_r;
    end else begin
      nxt_bit_s = pat_shift_s[0];
    end
`endif
  end

  // Start edge detector; held at 1 in reset so a level Start does not launch
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      start_prev_r <= 1'b1;
    end else begin
      start_prev_r <= sif.Start;
    end
  end

`ifdef WSTREAM_PARITY_EN
  // Parity of the captured data, fixed for the whole transfer
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      par_r <= 1'b0;
    end else if (launch_s) begin
      par_r <= parity_of(sif.Pattern, len_eff_s);
    end else begin
      par_r <= par_r;
    end
  end
`endif

  // Control FSM, divider, bit counter and registered outputs
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_r   <= ST_IDLE;
      pat_r     <= {WIDTH{1'b0}};
      len_r     <= IDX_ZERO;
      div_r     <= DIV_ZERO;
      bit_idx_r <= IDX_ZERO;
      w_r       <= 1'b0;
      step_r    <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (launch_s) begin
            pat_r     <= sif.Pattern;
            len_r     <= len_eff_s;
            div_r     <= DIV_ZERO;
            bit_idx_r <= IDX_ZERO;
            w_r       <= sif.Pattern[0];
            step_r    <= 1'b1;
            busy_r    <= 1'b1;
            state_r   <= ST_SHIFT;
          end else begin
            w_r    <= 1'b0;
            step_r <= 1'b0;
            busy_r <= 1'b0;
          end
        end
        ST_SHIFT: begin
          if (sif.Stop) begin
            state_r   <= ST_IDLE;
            div_r     <= DIV_ZERO;
            bit_idx_r <= IDX_ZERO;
            w_r       <= 1'b0;
            step_r    <= 1'b0;
            busy_r    <= 1'b0;
          end else if (bit_end_s && last_bit_s && !sif.Repeat) begin
            state_r   <= ST_DONE;
            div_r     <= DIV_ZERO;
            bit_idx_r <= IDX_ZERO;
            w_r       <= 1'b0;
            step_r    <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b1;
          end else if (bit_end_s) begin
            // Next bit, or wrap to bit 0 with no gap when repeating
            div_r     <= DIV_ZERO;
            bit_idx_r <= nxt_idx_s;
            w_r       <= nxt_bit_s;
            step_r    <= 1'b1;
          end else begin
            div_r  <= div_r + DIV_ONE;
            step_r <= 1'b0;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          done_r  <= 1'b0;
        end
        default: begin
          state_r   <= ST_IDLE;
          div_r     <= DIV_ZERO;
          bit_idx_r <= IDX_ZERO;
          w_r       <= 1'b0;
          step_r    <= 1'b0;
          busy_r    <= 1'b0;
          done_r    <= 1'b0;
        end
      endcase
    end
  end

  assign sif.w      = w_r;
  assign sif.Step   = step_r;
  assign sif.Busy   = busy_r;
  assign sif.Done   = done_r;
  assign sif.BitIdx = bit_idx_r;

endmodule
